// File: rtl/dff_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dff_pipe : DEPTH-stage WIDTH-bit pipeline register, valid/ready, flush   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module dff_pipe #(
   parameter int               WIDTH     = 8,
   parameter int               DEPTH     = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                       clk,
   input  logic                       rstb,
   input  logic [WIDTH-1:0]           d,
   input  logic                       d_valid,
   output logic                       d_ready,
   input  logic                       flush,
   output logic [WIDTH-1:0]           q,
   output logic                       q_valid,
   input  logic                       q_ready,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] data_q [DEPTH];
   logic [WIDTH-1:0] data_d [DEPTH];
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [DEPTH-1:0] adv, load;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             accept, fire;

   // A stage advances when everything downstream can make room: either the
   // consumer takes q, or some later stage is empty (bubble collapse).
   always_comb begin : p_adv
      logic room;
      room = q_ready;
      adv  = '0;
      for (int i = DEPTH-1; i >= 0; i--) begin
         adv[i] = valid_q[i] & room;
         room   = room | ~valid_q[i];
      end
   end

   assign load    = ~valid_q | adv;
   assign d_ready = load[0] & ~flush;
   assign accept  = d_valid & d_ready;
   assign fire    = valid_q[DEPTH-1] & q_ready;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      if (flush) begin
         valid_d = '0;
         cnt_d   = '0;
      end else begin
         if (load[0]) begin
            if (accept) data_d[0] = d;
            valid_d[0] = accept;
         end
         for (int i = 1; i < DEPTH; i++) begin
            if (load[i]) begin
               if (valid_q[i-1]) data_d[i] = data_q[i-1];
               valid_d[i] = valid_q[i-1];
            end
         end
         if (accept && !fire)      cnt_d = cnt_q + CW'(1);
         else if (fire && !accept) cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         for (int i = 0; i < DEPTH; i++) data_q[i] <= RESET_VAL;
         valid_q <= '0;
         cnt_q   <= '0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign q       = data_q[DEPTH-1];
   assign q_valid = valid_q[DEPTH-1];
   assign count   = cnt_q;

endmodule
`default_nettype wire
